// File: rtl/cmlk_3d_data_unpack.sv
// cmlk_3d_data_unpack: splits a 2*HALF_W-bit word stream into a HALF_W-bit sample
// stream (counterpart of the 16->32 packer). Two samples per accepted word, with
// no bubbles when both sides are always ready.
// Optional feature: define CMLK_3D_UNPACK_STAT_EN to add the stat_words port,
// a wrapping 16-bit count of accepted words.
module cmlk_3d_data_unpack #(
  parameter int HALF_W   = 16,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*HALF_W-1:0] din,
  input  logic                din_vld,
  output logic                din_rdy,
  output logic [HALF_W-1:0]   dout,
  output logic                dout_vld,
  input  logic                dout_rdy
`ifdef CMLK_3D_UNPACK_STAT_EN
  ,
  output logic [15:0]         stat_words
`endif
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FIRST, ST_SECOND} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2*HALF_W-1:0] r_word;
  logic                w_cap;
  logic                w_din_rdy;
  logic [HALF_W-1:0]   w_hi;
  logic [HALF_W-1:0]   w_lo;

  assign w_hi = r_word[2*HALF_W-1:HALF_W];
  assign w_lo = r_word[HALF_W-1:0];

  // State register: holds which half of the captured word is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state and input handshake; a new word is only taken once the last half leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_din_rdy   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_din_rdy = 1'b1;
        if (din_vld) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (dout_rdy) w_state_nxt = ST_SECOND;
      end
      ST_SECOND: begin
        if (dout_rdy) begin
          w_din_rdy = 1'b1;
          if (din_vld) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_FIRST;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Word register: changes only on an input transfer, i.e. after the second half left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_word <= '0;
    else if (w_cap) r_word <= din;
  end

  // Ready is suppressed while reset is asserted so nothing upstream sees a handshake.
  assign din_rdy  = rst_n & w_din_rdy;
  assign dout_vld = (r_state != ST_EMPTY);

  // Output half select; FIRST shows the packer's first sample, SECOND the other half.
  always_comb begin
    dout = '0;
    case (r_state)
      ST_FIRST:  dout = HI_FIRST ? w_hi : w_lo;
      ST_SECOND: dout = HI_FIRST ? w_lo : w_hi;
      default:   dout = '0;
    endcase
  end

`ifdef CMLK_3D_UNPACK_STAT_EN
  logic [15:0] r_stat_words;

  // Accepted-word counter, wraps naturally at 16 bits; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_stat_words <= '0;
    else if (din_vld && din_rdy) r_stat_words <= r_stat_words + 16'd1;
  end

  assign stat_words = r_stat_words;
`endif

endmodule

// File: tb/tb_cmlk_3d_data_unpack.sv
// Directed bench for cmlk_3d_data_unpack: expected samples are queued when a word
// is accepted and checked in order when the DUT hands a sample downstream.
module tb_cmlk_3d_data_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;

  logic [31:0] lo_din;
  logic        lo_din_vld;
  logic        lo_din_rdy;
  logic [15:0] lo_dout;
  logic        lo_dout_vld;
  logic        lo_dout_rdy;

`ifdef CMLK_3D_UNPACK_STAT_EN
  logic [15:0] stat_words;
  logic [15:0] lo_stat_words;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  int          cyc      = 0;
  logic [15:0] sb[$];
  int          out_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cmlk_3d_data_unpack #(.HALF_W(16), .HI_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy)
`ifdef CMLK_3D_UNPACK_STAT_EN
    , .stat_words(stat_words)
`endif
  );

  cmlk_3d_data_unpack #(.HALF_W(16), .HI_FIRST(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .din(lo_din), .din_vld(lo_din_vld), .din_rdy(lo_din_rdy),
    .dout(lo_dout), .dout_vld(lo_dout_vld), .dout_rdy(lo_dout_rdy)
`ifdef CMLK_3D_UNPACK_STAT_EN
    , .stat_words(lo_stat_words)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a word and hold it until accepted; expected halves are queued on acceptance.
  task automatic send(input logic [31:0] w);
    bit ok = 1'b0;
    din     = w;
    din_vld = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (din_rdy) begin
        sb.push_back(w[31:16]);
        sb.push_back(w[15:0]);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: every downstream transfer must match the oldest queued half.
  always @(negedge clk) begin
    if (rst_n && dout_vld && dout_rdy) begin
      n_out++;
      out_cyc.push_back(cyc);
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed %h expected none", dout);
      end
      if (sb.size() != 0) chk("sb_sample", {16'h0, dout}, {16'h0, sb.pop_front()});
    end
  end

  initial begin
    int mark;
    rst_n = 1'b0; din = 32'hFFFF_FFFF; din_vld = 1'b1; dout_rdy = 1'b1;
    lo_din = '0; lo_din_vld = 1'b0; lo_dout_rdy = 1'b1;

    // 1 reset with din_vld high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    din_vld = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rel_din_rdy", din_rdy, 1);
    chk("rel_dout_vld", dout_vld, 0);
`ifdef CMLK_3D_UNPACK_STAT_EN
    chk("rel_stat", stat_words, 0);
`endif
    @(posedge clk); #1;

    // 2 single word, upper half first
    send(32'hAAAA_5555);
    din_vld = 1'b0;
    @(negedge clk); chk("single_first", {dout_vld, dout}, {1'b1, 16'hAAAA});
    @(negedge clk); chk("single_second", {dout_vld, dout}, {1'b1, 16'h5555});
    @(negedge clk); chk("single_done_vld", dout_vld, 0);
    @(posedge clk); #1;

    // 3 back-to-back stream, eight samples with no gaps
    mark = out_cyc.size();
    for (int k = 0; k < 4; k++) send({16'(2*k+1), 16'(2*k+2)});
    din_vld = 1'b0;
    idle(4);
    chk("stream_count", out_cyc.size() - mark, 8);
    chk("stream_span", out_cyc[out_cyc.size()-1] - out_cyc[mark], 7);
`ifdef CMLK_3D_UNPACK_STAT_EN
    chk("stream_stat", stat_words, 5);
`endif

    // 4 backpressure in FIRST then SECOND; a waiting word must be ignored meanwhile
    send(32'hBEEF_CAFE);
    dout_rdy = 1'b0; din = 32'h1111_2222; din_vld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_first", {din_rdy, dout_vld, dout}, {1'b0, 1'b1, 16'hBEEF});
    end
    @(posedge clk); #1; dout_rdy = 1'b1;
    @(posedge clk); #1; dout_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_second", {din_rdy, dout_vld, dout}, {1'b0, 1'b1, 16'hCAFE});
    end
    @(posedge clk); #1; dout_rdy = 1'b1;
    send(32'h1111_2222);
    din_vld = 1'b0;
    idle(4);
    chk("bp_drained", sb.size(), 0);

    // 5 reset after the first half goes out; second half must be discarded
    send(32'h1234_5678);
    din_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk); chk("midrst_vld", dout_vld, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    mark = n_out;
    repeat (3) begin
      @(negedge clk); chk("midrst_quiet", dout_vld, 0);
    end
    chk("midrst_no_out", n_out - mark, 0);
    @(posedge clk); #1;
    send(32'h9ABC_DEF0);
    din_vld = 1'b0;
    idle(4);
    chk("midrst_next_count", n_out - mark, 2);
`ifdef CMLK_3D_UNPACK_STAT_EN
    chk("midrst_stat", stat_words, 1);
`endif

    // 6 lower-half-first instance
    lo_din = 32'hAAAA_5555; lo_din_vld = 1'b1;
    @(negedge clk); chk("lo_rdy", lo_din_rdy, 1);
    @(posedge clk); #1; lo_din_vld = 1'b0;
    @(negedge clk); chk("lo_first", {lo_dout_vld, lo_dout}, {1'b1, 16'h5555});
    @(negedge clk); chk("lo_second", {lo_dout_vld, lo_dout}, {1'b1, 16'hAAAA});
    @(negedge clk); chk("lo_done", lo_dout_vld, 0);

    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
